async_bus_capture: RTL and testbench
====================================

// Module: async_bus_capture
// PURPOSE
//   Captures an N-bit word from an external asynchronous source that marks valid data with a strobe.
//   Strobe passes through a 2-flop synchronizer plus an edge flop; an FSM waits SETTLE cycles,
//   samples the data bus twice and accepts the word only if both samples match.
//   Accepted words go out on a valid/ready interface to the detector datapath, with error/overrun flags.
// PARAMETERS
//   N          16  data bus width
//   SETTLE     2   clk cycles waited after detected strobe edge before first sample (0 allowed)
//   MAX_RETRY  3   sample-pair mismatches tolerated before word is discarded (>=1)
// PORTS
//   clk         in   1  system clock
//   rst         in   1  reset, asynchronous, active-high
//   ext_strobe  in   1  async strobe; rising edge = new word on ext_data, held high >= 1 clk
//   ext_data    in   N  async data bus; nominally stable while ext_strobe high
//   out_data    out  N  accepted word
//   out_valid   out  1  out_data valid; held until out_ready
//   out_ready   in   1  downstream accepts when out_valid & out_ready
//   err_unstable out 1  1-cycle pulse: word discarded after MAX_RETRY mismatches
//   overrun     out  1  sticky: strobe edge ignored or accepted word dropped
//   clr_flags   in   1  synchronous clear of overrun
//   busy        out  1  FSM not in IDLE
// BEHAVIOUR
//   Reset: out_data=0, out_valid=0, err_unstable=0, overrun=0, busy=0.
//     Also clears state=IDLE, all sync/edge/data flops and counters.
//   Strobe path: s1<=ext_strobe, s2<=s1, s3<=s2; edge = s2 & ~s3.
//     Async rise -> edge seen 2-3 clk later.
//     Strobe high at reset release is treated as a rising edge, because the sync flops start at 0.
//   Data path: d1<=ext_data, d2<=d1 every cycle. Only d2 is sampled/compared.
//   FSM states: IDLE, SETTLE, SAMPLE_A, SAMPLE_B, WAIT_LOW.
//     IDLE:     on edge, go to SETTLE (cnt=0); if SETTLE==0, go directly to SAMPLE_A. retry=0.
//     SETTLE:   cnt++; go to SAMPLE_A when cnt==SETTLE-1.
//     SAMPLE_A: capt<=d2; go to SAMPLE_B.
//     SAMPLE_B: if d2==capt, deliver capt (see output rule), then go to WAIT_LOW.
//               On mismatch: retry++.
//               If retry+1 < MAX_RETRY, go to SAMPLE_A.
//               Otherwise pulse err_unstable for 1 clk and go to WAIT_LOW (word discarded).
//     WAIT_LOW: go to IDLE when s2==0.
//   Latency: edge at cycle E -> out_valid=1 at E+SETTLE+3 with no mismatch.
//     Each retry adds 2 cycles.
//   Output rule at delivery:
//     - out_valid==0, or out_valid & out_ready in the same cycle: load out_data and set out_valid=1.
//     - out_valid & ~out_ready: new word dropped, out_data unchanged, overrun set.
//   out_valid clears on a transfer cycle when no new delivery occurs in that cycle.
//   out_data is stable while out_valid=1 & ~out_ready.
//   Edge detected in any state other than IDLE: ignored, overrun set.
//   overrun: sticky until clr_flags. If set and clear occur in the same cycle, set wins.
//   Reset mid-operation: partial word abandoned, no output pulse. Normal operation resumes per rules above.
//   busy = (state != IDLE). retry counter width = clog2(MAX_RETRY+1).
// TESTING
//   1. N=16, SETTLE=2: ext_data=16'hA5C3, strobe rises.
//      -> out_valid at edge+5 with out_data=A5C3; handshake with out_ready=1 clears out_valid next cycle.
//   2. SETTLE=0: ext_data=16'h1234, strobe held 10 clk.
//      -> exactly one word 1234 at edge+3; no retrigger while strobe high.
//   3. ext_data toggles 0000/FFFF every clk during sampling, MAX_RETRY=3.
//      -> err_unstable single pulse, no out_valid, FSM back in IDLE after strobe low.
//   4. out_ready=0: deliver 0x0001, then strobe a second word 0x0002.
//      -> out_data stays 0001, overrun=1; clr_flags -> overrun=0.
//   5. Strobe pulses low-then-high during SETTLE.
//      -> overrun=1, first word still delivered once; out_valid&out_ready on delivery cycle replaces word cleanly.
//   6. Assert rst during SAMPLE_B.
//      -> all outputs 0 immediately; with ext_strobe held high, the next capture completes after rst release.

Source files
------------

// File: rtl/async_bus_capture.sv
// Captures a word from an asynchronous strobe/data source: synchronises the strobe, double-samples
// the data bus and hands matching words to a valid/ready consumer with unstable/overrun flags.
module async_bus_capture #(
  parameter int unsigned N         = 16,
  parameter int unsigned SETTLE    = 2,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ext_strobe,
  input  logic [N-1:0] ext_data,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         err_unstable,
  output logic         overrun,
  input  logic         clr_flags,
  output logic         busy
);

  localparam int unsigned RW = $clog2(MAX_RETRY + 1);
  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CntLast = CW'((SETTLE == 0) ? 32'd0 : SETTLE - 32'd1);

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StSampleA,
    StSampleB,
    StWaitLow
  } state_e;

  state_e        state_q, state_d;
  logic          s1_q, s2_q, s3_q;
  logic [N-1:0]  d1_q, d2_q;
  logic [N-1:0]  capt_q, capt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [N-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          err_q, err_d;
  logic          overrun_q, overrun_d;
  logic          overrun_set;
  logic          strobe_edge;
  logic          deliver;

  // The sync flops reset to 0, so a strobe already high at reset release reads as a rising edge.
  assign strobe_edge = s2_q & ~s3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
      d1_q <= '0;
      d2_q <= '0;
    end else begin
      s1_q <= ext_strobe;
      s2_q <= s1_q;
      s3_q <= s2_q;
      d1_q <= ext_data;
      d2_q <= d1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      retry_q <= '0;
      capt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      capt_q  <= capt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    capt_d  = capt_q;
    deliver = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (strobe_edge) begin
          cnt_d   = '0;
          retry_d = '0;
          state_d = (SETTLE == 0) ? StSampleA : StSettle;
        end
      end
      StSettle: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StSampleA;
        end
      end
      StSampleA: begin
        capt_d  = d2_q;
        state_d = StSampleB;
      end
      StSampleB: begin
        if (d2_q == capt_q) begin
          deliver = 1'b1;
          state_d = StWaitLow;
        end else begin
          retry_d = retry_q + 1'b1;
          if ((32'(retry_q) + 32'd1) < MAX_RETRY) begin
            state_d = StSampleA;
          end else begin
            err_d   = 1'b1;
            state_d = StWaitLow;
          end
        end
      end
      StWaitLow: begin
        if (!s2_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A delivery may coincide with a transfer of the previous word; only a stalled slot drops it.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_set = strobe_edge && (state_q != StIdle);
    if (deliver) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = capt_q;
        out_valid_d = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    overrun_d = (overrun_q & ~clr_flags) | overrun_set;
    busy      = (state_q != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign err_unstable = err_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_async_bus_capture.sv
// Bench for async_bus_capture: two instances (SETTLE=2 and SETTLE=0) share stimulus and are checked
// every cycle against a job/timeline model built from the input history.
module tb_async_bus_capture;

  localparam int MAXR = 3;
  localparam int MAXC = 8192;
  localparam int SETTLE0 = 2;
  localparam int SETTLE1 = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ext_strobe = 1'b0;
  logic [15:0] ext_data = '0;
  logic        out_ready = 1'b0;
  logic        clr_flags = 1'b0;

  logic [15:0] od0, od1;
  logic        ov0, ov1, er0, er1, or0, or1, bs0, bs1;

  always #5 clk = ~clk;

  async_bus_capture #(.N(16), .SETTLE(SETTLE0), .MAX_RETRY(MAXR)) dut0 (
    .clk(clk), .rst(rst), .ext_strobe(ext_strobe), .ext_data(ext_data),
    .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .err_unstable(er0),
    .overrun(or0), .clr_flags(clr_flags), .busy(bs0)
  );

  async_bus_capture #(.N(16), .SETTLE(SETTLE1), .MAX_RETRY(MAXR)) dut1 (
    .clk(clk), .rst(rst), .ext_strobe(ext_strobe), .ext_data(ext_data),
    .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .err_unstable(er1),
    .overrun(or1), .clr_flags(clr_flags), .busy(bs1)
  );

  // A capture job: started by an edge at cycle je, attempt jk, wt = waiting for strobe low.
  typedef struct {
    bit          act;
    bit          wt;
    int          je;
    int          jk;
    bit          mv;
    logic [15:0] md;
    bit          er;
    bit          ovr;
  } mdl_t;

  mdl_t        m [2];
  int          settle_p [2];
  bit          st_h [MAXC];
  logic [15:0] dt_h [MAXC];
  int          cyc_n = 0;
  int          rst_mark = -1;
  int          n_chk = 0;
  int          n_pass = 0;

  bit          st = 1'b0, rdy = 1'b0, clr = 1'b0, rst_req = 1'b0;
  logic [15:0] dt = '0;

  function automatic bit s_at(input int j);
    if (j < 0 || j <= rst_mark) return 1'b0;
    return st_h[j];
  endfunction

  function automatic logic [15:0] d_at(input int j);
    if (j < 0 || j <= rst_mark) return 16'h0;
    return dt_h[j];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc_n, got, exp);
  endtask

  task automatic mdl_reset(input int i);
    m[i].act = 1'b0; m[i].wt = 1'b0; m[i].je = 0; m[i].jk = 0;
    m[i].mv = 1'b0; m[i].md = '0; m[i].er = 1'b0; m[i].ovr = 1'b0;
  endtask

  // Advance model i over cycle c; fields then describe the outputs seen in cycle c+1.
  task automatic step(input int i, input int c);
    bit          e, dlv, set, err;
    logic [15:0] w;
    int          a;
    e   = s_at(c - 2) && !s_at(c - 3);
    dlv = 1'b0; set = 1'b0; err = 1'b0; w = '0;
    if (!m[i].act) begin
      if (e) begin
        m[i].act = 1'b1; m[i].wt = 1'b0; m[i].je = c; m[i].jk = 0;
      end
    end else begin
      if (e) set = 1'b1;
      if (m[i].wt) begin
        if (!s_at(c - 2)) m[i].act = 1'b0;
      end else begin
        a = m[i].je + 1 + settle_p[i] + 2 * m[i].jk;
        if (c == a + 1) begin
          if (d_at(a - 2) == d_at(c - 2)) begin
            dlv = 1'b1; w = d_at(a - 2); m[i].wt = 1'b1;
          end else if (m[i].jk + 1 < MAXR) begin
            m[i].jk = m[i].jk + 1;
          end else begin
            err = 1'b1; m[i].wt = 1'b1;
          end
        end
      end
    end
    if (dlv) begin
      if (!m[i].mv || rdy) begin
        m[i].md = w; m[i].mv = 1'b1;
      end else begin
        set = 1'b1;
      end
    end else if (m[i].mv && rdy) begin
      m[i].mv = 1'b0;
    end
    m[i].ovr = (m[i].ovr && !clr) || set;
    m[i].er  = err;
  endtask

  task automatic cmp_model(input int i, input logic v, input logic [15:0] d, input logic e,
                           input logic o, input logic b);
    chk($sformatf("dut%0d out_valid", i), 32'(v), 32'(m[i].mv));
    chk($sformatf("dut%0d out_data", i), 32'(d), 32'(m[i].md));
    chk($sformatf("dut%0d err_unstable", i), 32'(e), 32'(m[i].er));
    chk($sformatf("dut%0d overrun", i), 32'(o), 32'(m[i].ovr));
    chk($sformatf("dut%0d busy", i), 32'(b), 32'(m[i].act));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " out_valid0"}, 32'(ov0), 0); chk({tag, " out_data0"}, 32'(od0), 0);
    chk({tag, " err0"}, 32'(er0), 0);       chk({tag, " overrun0"}, 32'(or0), 0);
    chk({tag, " busy0"}, 32'(bs0), 0);
    chk({tag, " out_valid1"}, 32'(ov1), 0); chk({tag, " out_data1"}, 32'(od1), 0);
    chk({tag, " err1"}, 32'(er1), 0);       chk({tag, " overrun1"}, 32'(or1), 0);
    chk({tag, " busy1"}, 32'(bs1), 0);
  endtask

  // One clock cycle: compare outputs, apply this cycle's inputs, advance the models.
  task automatic cyc();
    @(negedge clk);
    if (cyc_n >= MAXC) begin
      $display("FAIL cycle budget: got %0d cycles, limit %0d", cyc_n, MAXC);
      $display("%0d/%0d checks passed", n_pass, n_chk + 1);
      $fatal(1);
    end
    cmp_model(0, ov0, od0, er0, or0, bs0);
    cmp_model(1, ov1, od1, er1, or1, bs1);
    ext_strobe = st; ext_data = dt; out_ready = rdy; clr_flags = clr;
    st_h[cyc_n] = st; dt_h[cyc_n] = dt;
    if (rst_req) begin
      rst = 1'b1;
      rst_req = 1'b0;
      #1;
      chk_zero("mid-op reset");
      rst_mark = cyc_n;
      mdl_reset(0); mdl_reset(1);
    end else begin
      rst = 1'b0;
      step(0, cyc_n); step(1, cyc_n);
    end
    cyc_n++;
  endtask

  task automatic idle(input int n);
    st = 1'b0;
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc_n);
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1);
  end

  initial begin
    int cnt0, cnt1, e0, e1, mode;
    settle_p[0] = SETTLE0;
    settle_p[1] = SETTLE1;
    mdl_reset(0); mdl_reset(1);
    repeat (2) @(negedge clk);
    chk_zero("reset");

    // 1: basic capture, SETTLE=2 valid at edge+5, SETTLE=0 at edge+3 (edge = rise+2)
    rdy = 1'b1; dt = 16'hA5C3;
    idle(6);
    st = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) st = 1'b0;
      cyc();
      if (i == 5) begin chk("t1 dut1 valid", 32'(ov1), 1); chk("t1 dut1 data", 32'(od1), 32'hA5C3); end
      if (i == 6) begin chk("t1 dut0 early", 32'(ov0), 0); chk("t1 dut1 cleared", 32'(ov1), 0); end
      if (i == 7) begin chk("t1 dut0 valid", 32'(ov0), 1); chk("t1 dut0 data", 32'(od0), 32'hA5C3); end
      if (i == 8) chk("t1 dut0 cleared", 32'(ov0), 0);
    end
    idle(4);

    // 2: strobe held 10 cycles -> exactly one word
    dt = 16'h1234; cnt0 = 0; cnt1 = 0; st = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) st = 1'b0;
      cyc();
      cnt0 += int'(ov0); cnt1 += int'(ov1);
      if (i == 5) chk("t2 dut1 data", 32'(od1), 32'h1234);
    end
    chk("t2 dut0 words", cnt0, 1);
    chk("t2 dut1 words", cnt1, 1);

    // 3: data toggling every cycle -> one err pulse, no word, back to idle
    cnt0 = 0; cnt1 = 0; e0 = 0; e1 = 0; st = 1'b1;
    for (int i = 0; i < 22; i++) begin
      dt = (i % 2 == 1) ? 16'hFFFF : 16'h0000;
      if (i == 14) st = 1'b0;
      cyc();
      cnt0 += int'(ov0); cnt1 += int'(ov1); e0 += int'(er0); e1 += int'(er1);
    end
    chk("t3 dut0 err pulses", e0, 1); chk("t3 dut1 err pulses", e1, 1);
    chk("t3 dut0 words", cnt0, 0);    chk("t3 dut1 words", cnt1, 0);
    chk("t3 dut0 idle", 32'(bs0), 0); chk("t3 dut1 idle", 32'(bs1), 0);

    // 4: stalled consumer -> second word dropped, overrun sticky until clr_flags
    rdy = 1'b0; clr = 1'b1; cyc(); clr = 1'b0;
    dt = 16'h0001; st = 1'b1;
    for (int i = 0; i < 14; i++) begin if (i == 4) st = 1'b0; cyc(); end
    dt = 16'h0002; st = 1'b1;
    for (int i = 0; i < 14; i++) begin if (i == 4) st = 1'b0; cyc(); end
    chk("t4 dut0 data kept", 32'(od0), 32'h0001); chk("t4 dut0 valid", 32'(ov0), 1);
    chk("t4 dut0 overrun", 32'(or0), 1);          chk("t4 dut1 overrun", 32'(or1), 1);
    clr = 1'b1; cyc(); clr = 1'b0; cyc();
    chk("t4 dut0 overrun cleared", 32'(or0), 0);  chk("t4 dut1 overrun cleared", 32'(or1), 0);
    chk("t4 dut1 data kept", 32'(od1), 32'h0001);
    rdy = 1'b1; idle(3);

    // 5: strobe glitch during settle -> overrun, word delivered once
    dt = 16'h5A5A; cnt0 = 0;
    for (int i = 0; i < 16; i++) begin
      st = (i == 0) || (i >= 2 && i <= 4);
      cyc();
      cnt0 += int'(ov0);
    end
    chk("t5 dut0 words", cnt0, 1); chk("t5 dut0 overrun", 32'(or0), 1);
    chk("t5 dut0 data", 32'(od0), 32'h5A5A);
    // Then a pending word is replaced by one delivered in a transfer cycle
    clr = 1'b1; cyc(); clr = 1'b0;
    rdy = 1'b0; dt = 16'h1111; st = 1'b1;
    for (int i = 0; i < 12; i++) begin if (i == 3) st = 1'b0; cyc(); end
    dt = 16'h2222; st = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) st = 1'b0;
      rdy = (i == 6);
      cyc();
      if (i == 7) begin
        chk("t5 replace valid", 32'(ov0), 1); chk("t5 replace data", 32'(od0), 32'h2222);
        chk("t5 replace no overrun", 32'(or0), 0);
      end
    end
    rdy = 1'b1; idle(4);

    // 6: reset during SAMPLE_B with strobe held high -> capture restarts after release
    dt = 16'hBEEF; st = 1'b1;
    for (int i = 0; i < 22; i++) begin
      rst_req = (i == 6);
      cyc();
      if (i == 12) begin chk("t6 dut1 valid", 32'(ov1), 1); chk("t6 dut1 data", 32'(od1), 32'hBEEF); end
      if (i == 13) chk("t6 dut0 early", 32'(ov0), 0);
      if (i == 14) begin chk("t6 dut0 valid", 32'(ov0), 1); chk("t6 dut0 data", 32'(od0), 32'hBEEF); end
    end
    idle(6);

    // Random traffic in alternating regimes
    for (int k = 0; k < 4000; k++) begin
      mode = (k / 250) % 3;
      if (mode == 0) begin
        if ($urandom_range(0, 11) == 0) st = ~st;
        if ($urandom_range(0, 7) == 0) dt = 16'($urandom);
      end else if (mode == 1) begin
        if ($urandom_range(0, 2) == 0) st = ~st;
        if ($urandom_range(0, 3) == 0) dt = 16'($urandom);
      end else begin
        if ($urandom_range(0, 7) == 0) st = ~st;
        if ($urandom_range(0, 1) == 0) dt = 16'($urandom);
      end
      rdy = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 15) == 0);
      rst_req = ($urandom_range(0, 999) == 0);
      cyc();
    end
    rst_req = 1'b0; rdy = 1'b1; clr = 1'b0;
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
